// File: rtl/cam_capture_ctrl.sv
// Frame-level sequencer for the OV7670 AXI-Stream capture block: start/stop,
// single/continuous capture with frame skipping, stream monitoring and stall watchdog.
module cam_capture_ctrl #(
  parameter int X_RES          = 640,
  parameter int Y_RES          = 480,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SKIP_W         = 4
) (
  input  logic              i_sysclk,
  input  logic              i_reset,
  input  logic              i_cfg_done,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_continuous,
  input  logic [SKIP_W-1:0] i_skip,
  input  logic              i_vsync,
  input  logic              i_mon_tvalid,
  input  logic              i_mon_tuser,
  input  logic              i_mon_tlast,
  input  logic              i_err_clear,
  output logic              o_cap_enable,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_frame_bad,
  output logic [15:0]       o_frame_count,
  output logic              o_err_line,
  output logic              o_err_timeout,
  output logic [2:0]        o_state
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BC_W = $clog2(X_RES + 2);
  localparam int LC_W = $clog2(Y_RES + 1);
  localparam logic [BC_W-1:0] BEAT_FULL = BC_W'(X_RES);
  localparam logic [BC_W-1:0] BEAT_SAT  = BC_W'(X_RES + 1);
  localparam logic [LC_W-1:0] LINE_FULL = LC_W'(Y_RES);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CFG, S_SKIP, S_ARM, S_CAPTURE, S_DONE
  } state_t;

  state_t state, next_state;

  logic              vs_meta, vs_sync, vs_prev;
  logic [SKIP_W-1:0] skip_n, skip_cnt;
  logic              cont, stop_pending, frame_err;
  logic [BC_W-1:0]   beat_cnt, beat_new;
  logic [LC_W-1:0]   line_cnt, line_base, line_new;
  logic [WD_W-1:0]   wdog;
  logic              cap_enable_q, frame_done_q, frame_bad_q, err_line_q, err_timeout_q;
  logic [15:0]       frame_count_q;
  logic              beat, sof, eol, vs_rise, active, capture_beat;
  logic              line_err_now, frame_end, timeout;

  // The monitored stream has no TREADY: a beat is any cycle with TVALID=1 and
  // TUSER/TLAST are only meaningful on such a cycle. The monitor never stalls it.
  always_comb begin
    beat         = i_mon_tvalid;
    sof          = beat & i_mon_tuser;
    eol          = beat & i_mon_tlast;
    vs_rise      = vs_sync & ~vs_prev;
    active       = (state == S_ARM) || (state == S_CAPTURE);
    capture_beat = ((state == S_ARM) && sof && !i_stop) || ((state == S_CAPTURE) && beat);
    beat_new     = sof ? BC_W'(1) :
                   ((beat_cnt >= BEAT_SAT) ? BEAT_SAT : beat_cnt + BC_W'(1));
    line_base    = sof ? '0 : line_cnt;
    line_new     = line_base + LC_W'(1);
    line_err_now = capture_beat &&
                   (((state == S_CAPTURE) && sof) || (eol && (beat_new != BEAT_FULL)));
    frame_end    = capture_beat && eol && (line_new == LINE_FULL);
    timeout      = active && !beat && (wdog == WD_LAST);
  end

  always_ff @(posedge i_sysclk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (i_start && !i_stop) next_state = S_WAIT_CFG;
      S_WAIT_CFG: if (i_stop) next_state = S_IDLE;
                  else if (i_cfg_done) next_state = (skip_n != '0) ? S_SKIP : S_ARM;
      S_SKIP:     if (i_stop) next_state = S_IDLE;
                  else if (vs_rise && (skip_cnt + SKIP_W'(1) == skip_n)) next_state = S_ARM;
      S_ARM:      if (i_stop || timeout) next_state = S_IDLE;
                  else if (frame_end) next_state = S_DONE;
                  else if (sof) next_state = S_CAPTURE;
      S_CAPTURE:  if (timeout) next_state = S_IDLE;
                  else if (frame_end) next_state = S_DONE;
      S_DONE:     if (cont && !stop_pending) next_state = (i_skip != '0) ? S_SKIP : S_ARM;
                  else next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (i_reset) begin
      vs_meta       <= 1'b0;
      vs_sync       <= 1'b0;
      vs_prev       <= 1'b0;
      skip_n        <= '0;
      skip_cnt      <= '0;
      cont          <= 1'b0;
      stop_pending  <= 1'b0;
      frame_err     <= 1'b0;
      beat_cnt      <= '0;
      line_cnt      <= '0;
      wdog          <= '0;
      cap_enable_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_bad_q   <= 1'b0;
      frame_count_q <= '0;
      err_line_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      vs_meta <= i_vsync;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;

      if (((state == S_IDLE) || (state == S_DONE)) && (next_state != S_IDLE)) begin
        skip_n <= i_skip;
        cont   <= i_continuous;
      end

      if (state != S_SKIP) skip_cnt <= '0;
      else if (vs_rise)    skip_cnt <= skip_cnt + SKIP_W'(1);

      if (next_state == S_IDLE)                    stop_pending <= 1'b0;
      else if ((state == S_CAPTURE) && i_stop)     stop_pending <= 1'b1;

      // Line/beat counters only live while a frame is being captured.
      if (next_state != S_CAPTURE) begin
        beat_cnt <= '0;
        line_cnt <= '0;
      end else if (capture_beat) begin
        beat_cnt <= eol ? '0 : beat_new;
        line_cnt <= eol ? line_new : line_base;
      end

      if ((next_state != S_ARM) && (next_state != S_CAPTURE)) frame_err <= 1'b0;
      else if (line_err_now)                                  frame_err <= 1'b1;

      if (active && (next_state == state) && !beat) wdog <= wdog + WD_W'(1);
      else                                          wdog <= '0;

      cap_enable_q <= (next_state == S_ARM) || (next_state == S_CAPTURE);
      frame_done_q <= (next_state == S_DONE);
      frame_bad_q  <= (next_state == S_DONE) && (frame_err || line_err_now);
      if (next_state == S_DONE) frame_count_q <= frame_count_q + 16'd1;

      if (line_err_now)     err_line_q <= 1'b1;
      else if (i_err_clear) err_line_q <= 1'b0;

      if (timeout)          err_timeout_q <= 1'b1;
      else if (i_err_clear) err_timeout_q <= 1'b0;
    end
  end

  always_comb begin
    o_busy        = (state != S_IDLE);
    o_cap_enable  = cap_enable_q;
    o_frame_done  = frame_done_q;
    o_frame_bad   = frame_bad_q;
    o_frame_count = frame_count_q;
    o_err_line    = err_line_q;
    o_err_timeout = err_timeout_q;
    o_state       = state;
  end

endmodule
